// File: rtl/mul_booth_seq.sv
// Radix-2 Booth sequential signed multiplier driving an external combinational adder.
// Result appears WIDTH+1 cycles after an accepted Start; Start is ignored while busy.
module mul_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic [WIDTH-1:0]     AddIn1,
  output logic [WIDTH-1:0]     AddIn2,
  input  logic [WIDTH-1:0]     AddOut,
  input  logic                 AddOverflow,
  input  logic                 AddCarry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     negm_q, negm_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     addend;
  logic                 sub_sel;
  logic                 neg_wrap;
  logic                 t_bit;
  logic                 unused_carry;

  assign unused_carry = AddCarry;

  always_comb begin
    sub_sel = q_q[0] & ~qm1_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   addend = m_q;
      2'b10:   addend = negm_q;
      default: addend = '0;
    endcase
    // -M for the most negative M wraps to itself; the true addend is +2^(WIDTH-1),
    // so its sign extension is 0 instead of 1 and the true sign flips.
    neg_wrap = sub_sel & (m_q == MOST_NEG);
    t_bit    = AddOut[WIDTH-1] ^ AddOverflow ^ neg_wrap;
  end

  assign AddIn1  = (state_q == RUN) ? a_q : '0;
  assign AddIn2  = (state_q == RUN) ? addend : '0;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Product = product_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    negm_d    = negm_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      RUN: begin
        a_d   = {t_bit, AddOut[WIDTH-1:1]};
        q_d   = {AddOut[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = DONE;
          product_d = {t_bit, AddOut, q_q[WIDTH-1:1]};
        end
      end
      default: begin
        state_d = IDLE;
        if (Start) begin
          a_d     = '0;
          q_d     = Multiplier;
          qm1_d   = 1'b0;
          m_d     = Multiplicand;
          negm_d  = (~Multiplicand) + ONE;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      negm_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      negm_q    <= negm_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
